seg_scan: RTL and testbench

- Six-digit seven-segment scan driver. Sits directly downstream of the 1 kHz divider.
- Consumes the divider's clk_1k square wave as a scan-rate source, sampled in the clk domain. Never used as a clock.
- Each clk_1k rising edge advances one digit. Per-digit blanking suppresses ghosting; a whole frame's data is latched atomically at the start of each frame.
- Drives active-low digit selects and segment lines to the board display.

---
 rtl/seg_scan.sv | 159 +++++++++++++++
 tb/tb_seg_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Six-digit seven-segment scan driver with per-digit blanking,
// frame-atomic data latching and leading-zero suppression.
module seg_scan #(
    parameter int DIGITS    = 6,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_1k,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [IW-1:0] LAST    = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_END = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                state;
    logic                  s1;
    logic                  s2;
    logic                  tick;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic                  wrap;
    logic [CW-1:0]         cnt;

    logic [4*DIGITS-1:0]   data_sh;
    logic [DIGITS-1:0]     dp_sh;
    logic [DIGITS-1:0]     en_sh;
    logic                  lz_sh;

    logic [DIGITS-1:0]     lz_mask;
    logic                  zrun;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  cur_lz;
    logic [DIGITS-1:0]     cur_sel;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        unique case (n)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            4'hF: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign tick    = s1 & ~s2;
    assign wrap    = (idx == LAST);
    assign idx_nxt = wrap ? '0 : idx + IW'(1);

    // Disabled digits are treated as zero so they never end the blank run.
    always_comb begin
        lz_mask = '0;
        zrun    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (en_sh[i] && (data_sh[4*i +: 4] != 4'h0))
                zrun = 1'b0;
            lz_mask[i] = lz_sh && (i != 0) && zrun;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = data_sh[4*i +: 4];
                cur_dp  = dp_sh[i];
                cur_en  = en_sh[i];
                cur_lz  = lz_mask[i];
            end
        end
        cur_sel = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            state       <= IDLE;
            idx         <= LAST;
            cnt         <= '0;
            data_sh     <= '0;
            dp_sh       <= '0;
            en_sh       <= '0;
            lz_sh       <= 1'b0;
            frame_start <= 1'b0;
            sel         <= '1;
            seg         <= 8'hFF;
        end else begin
            s1          <= clk_1k;
            s2          <= s1;
            frame_start <= 1'b0;
            sel         <= '1;
            seg         <= 8'hFF;

            if (state == SHOW && cur_en) begin
                sel <= cur_sel;
                seg <= {~cur_dp, cur_lz ? 7'h7F : hex7(cur_nib)};
            end

            if (tick) begin
                idx   <= idx_nxt;
                state <= BLANK;
                cnt   <= '0;
                if (wrap) begin
                    data_sh     <= data_in;
                    dp_sh       <= dp_in;
                    en_sh       <= en_in;
                    lz_sh       <= lz_en;
                    frame_start <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    BLANK: begin
                        if (cnt == CNT_END)
                            state <= SHOW;
                        else
                            cnt <= cnt + CW'(1);
                    end
                    SHOW: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: fixed frame table, hand sequences
// for mid-frame input change and reset, then randomized frames.
module tb_seg_scan;

    localparam int N = 6;
    localparam int B = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clk_1k = 1'b0;
    logic [4*N-1:0]  data_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic [N-1:0]    en_in = '0;
    logic            lz_en = 1'b0;
    logic [N-1:0]    sel;
    logic [7:0]      seg;
    logic            frame_start;

    int errors = 0;
    int checks = 0;

    seg_scan #(.DIGITS(N), .BLANK_CYC(B)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_1k(clk_1k),
        .data_in(data_in),
        .dp_in(dp_in),
        .en_in(en_in),
        .lz_en(lz_en),
        .sel(sel),
        .seg(seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Active-high gfedcba patterns; the model inverts them.
    logic [6:0] hex_on [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [4*N-1:0] m_data;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_en;
    logic           m_lz;
    int             m_idx;

    typedef struct {
        logic [23:0]     data;
        logic [5:0]      dp;
        logic [5:0]      en;
        logic            lz;
        logic [5:0][5:0] esel;
        logic [5:0][7:0] eseg;
    } frame_t;

    frame_t tbl [4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] model_out(input int i);
        logic [4*N-1:0] mask;
        logic [4*N-1:0] above;
        int             nib;
        logic           supp;
        logic [5:0]     s;
        logic [7:0]     g;
        if (!m_en[i]) return {6'h3F, 8'hFF};
        mask = '0;
        for (int j = 0; j < N; j++)
            if (m_en[j]) mask = mask | (24'hF << (4 * j));
        above = (m_data & mask) >> (4 * i);
        nib   = int'((m_data >> (4 * i)) & 24'hF);
        supp  = m_lz && (i > 0) && (above == 0);
        s     = 6'h3F ^ (6'h01 << i);
        g     = {~m_dp[i], supp ? 7'h7F : ~hex_on[nib]};
        return {s, g};
    endfunction

    task automatic model_tick(output logic [13:0] e, output logic fs);
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
        fs = (m_idx == 0);
        if (fs) begin
            m_data = data_in;
            m_dp   = dp_in;
            m_en   = en_in;
            m_lz   = lz_en;
        end
        e = model_out(m_idx);
    endtask

    task automatic run_slot(input logic [5:0] es, input logic [7:0] eg,
                            input logic efs, input string tag);
        int fsc;
        int darkbad;
        int unstable;
        fsc = 0;
        darkbad = 0;
        unstable = 0;
        @(negedge clk);
        clk_1k = 1'b1;
        for (int k = 1; k <= B + 30; k++) begin
            @(negedge clk);
            if (k == 10) clk_1k = 1'b0;
            if (k <= 4) fsc += int'(frame_start);
            if (k >= 3 && k <= B + 2 && (sel !== 6'h3F || seg !== 8'hFF))
                darkbad++;
            if (k == B + 3) begin
                check({tag, " sel"}, 32'(sel), 32'(es));
                check({tag, " seg"}, 32'(seg), 32'(eg));
            end
            if (k > B + 3 && (sel !== es || seg !== eg)) unstable++;
        end
        check({tag, " frame_start"}, fsc, 32'(efs));
        check({tag, " blank"}, darkbad, 0);
        check({tag, " hold"}, unstable, 0);
    endtask

    task automatic model_slot(input string tag);
        logic [13:0] e;
        logic        fs;
        model_tick(e, fs);
        run_slot(e[13:8], e[7:0], fs, tag);
    endtask

    initial begin
        logic [13:0] e;
        logic        fs;
        int          bad;

        tbl[0] = '{24'h123456, 6'h00, 6'h3F, 1'b0,
                   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                   {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
        tbl[1] = '{24'h000705, 6'h20, 6'h3F, 1'b1,
                   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                   {8'h7F, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'h92}};
        tbl[2] = '{24'h123456, 6'h00, 6'h3B, 1'b0,
                   {6'h1F, 6'h2F, 6'h37, 6'h3F, 6'h3D, 6'h3E},
                   {8'hF9, 8'hA4, 8'hB0, 8'hFF, 8'h92, 8'h82}};
        tbl[3] = '{24'h500012, 6'h01, 6'h1F, 1'b1,
                   {6'h3F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'h24}};

        m_data = '0;
        m_dp   = '0;
        m_en   = '0;
        m_lz   = 1'b0;
        m_idx  = N - 1;

        repeat (3) @(negedge clk);
        check("reset sel", 32'(sel), 32'h3F);
        check("reset seg", 32'(seg), 32'hFF);
        check("reset frame_start", 32'(frame_start), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (sel !== 6'h3F || seg !== 8'hFF || frame_start !== 1'b0)
                bad++;
        end
        check("post-release dark", bad, 0);

        for (int f = 0; f < 4; f++) begin
            data_in = tbl[f].data;
            dp_in   = tbl[f].dp;
            en_in   = tbl[f].en;
            lz_en   = tbl[f].lz;
            for (int d = 0; d < N; d++) begin
                model_tick(e, fs);
                run_slot(tbl[f].esel[d], tbl[f].eseg[d], d == 0,
                         $sformatf("tbl%0d d%0d", f, d));
            end
        end

        data_in = 24'h123456;
        dp_in   = 6'h00;
        en_in   = 6'h3F;
        lz_en   = 1'b0;
        model_slot("mid d0");
        model_slot("mid d1");
        model_slot("mid d2");
        data_in = 24'hABCDEF;
        model_tick(e, fs);
        run_slot(6'h37, 8'hB0, 1'b0, "mid d3 old");
        model_tick(e, fs);
        run_slot(6'h2F, 8'hA4, 1'b0, "mid d4 old");
        model_tick(e, fs);
        run_slot(6'h1F, 8'hF9, 1'b0, "mid d5 old");
        model_tick(e, fs);
        run_slot(6'h3E, 8'h8E, 1'b1, "new d0");
        for (int d = 1; d < N; d++)
            model_slot($sformatf("new d%0d", d));

        data_in = 24'h123456;
        model_slot("rst d0");
        model_slot("rst d1");
        model_slot("rst d2");
        model_tick(e, fs);
        @(negedge clk);
        clk_1k = 1'b1;
        for (int k = 1; k <= B + 6; k++) begin
            @(negedge clk);
            if (k == 10) clk_1k = 1'b0;
        end
        check("rst d3 lit sel", 32'(sel), 32'(e[13:8]));
        check("rst d3 lit seg", 32'(seg), 32'(e[7:0]));
        rst_n = 1'b0;
        #1;
        check("async rst sel", 32'(sel), 32'h3F);
        check("async rst seg", 32'(seg), 32'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (sel !== 6'h3F || seg !== 8'hFF || frame_start !== 1'b0)
                bad++;
        end
        check("after rst dark", bad, 0);
        m_idx = N - 1;
        for (int d = 0; d < N; d++)
            model_slot($sformatf("restart d%0d", d));

        for (int s = 0; s < 4 * N; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                data_in = 24'($urandom);
                if ($urandom_range(0, 1) == 0)
                    data_in = data_in & 24'h00FFFF;
                dp_in = 6'($urandom);
                en_in = 6'($urandom) | 6'h30;
                lz_en = 1'($urandom);
            end
            model_slot($sformatf("rand s%0d", s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
